elevator_call_dispatcher: RTL

Request-side companion to the elevator controller FSM. Latches floor calls and tracks car position by counting travel cycles while the controller's motor outputs are active. Selects the next target floor and drives the controller's `button_up`, `button_down` and `door_open` inputs. Sits between the floor call panels and the elevator controller, closing the loop on its motor/door outputs.

---
 rtl/elevator_call_dispatcher.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher
// Request-side companion to the elevator controller. Latches floor calls,
// tracks the car position by counting motor-active cycles, picks the next
// destination in SCAN order and drives the controller's button/door inputs.
module elevator_call_dispatcher #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  call_req,
    input  logic               elevator_motor_up,
    input  logic               elevator_motor_down,
    input  logic               door_motor_open,
    input  logic               door_motor_close,
    output logic               button_up,
    output logic               button_down,
    output logic               door_open,
    output logic [FLOOR_W-1:0] current_floor,
    output logic [FLOOR_W-1:0] target_floor,
    output logic [FLOORS-1:0]  pending,
    output logic               busy,
    output logic               fault
);

    localparam int                 CNT_W     = $clog2(TRAVEL_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

    typedef enum logic [2:0] {
        D_IDLE   = 3'd0,
        D_REQ    = 3'd1,
        D_TRAVEL = 3'd2,
        D_ARRIVE = 3'd3,
        D_DOOR   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   travel_cnt;
    logic [CNT_W-1:0]   travel_cnt_nxt;
    logic               dir_up;
    logic               dir_up_nxt;
    logic               button_up_nxt;
    logic               button_down_nxt;
    logic               door_open_nxt;
    logic               fault_nxt;
    logic [FLOOR_W-1:0] current_floor_nxt;
    logic [FLOOR_W-1:0] target_floor_nxt;
    logic [FLOORS-1:0]  clear_mask;

    logic               motors_quiet;
    logic               here_pending;
    logic               committed_motor;
    logic               wrong_dir;
    logic               dispatch;
    logic               step_due;
    logic [FLOOR_W-1:0] step_floor;
    logic               step_oob;

    logic               up_found;
    logic               dn_found;
    logic [FLOOR_W-1:0] up_floor;
    logic [FLOOR_W-1:0] dn_floor;
    logic               sel_up;
    logic [FLOOR_W-1:0] sel_floor;

    // One-hot mask selecting a single floor's pending bit
    function automatic logic [FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] m;
        m    = '0;
        m[f] = 1'b1;
        return m;
    endfunction

    // Controller activity decoded against the committed travel direction
    always_comb begin
        motors_quiet    = ~(elevator_motor_up | elevator_motor_down |
                            door_motor_open | door_motor_close);
        here_pending    = pending[current_floor];
        committed_motor = dir_up ? elevator_motor_up : elevator_motor_down;
        wrong_dir       = dir_up ? elevator_motor_down : elevator_motor_up;
        dispatch        = (state == D_IDLE) && motors_quiet && !here_pending &&
                          (pending != '0);
        step_due        = (state == D_TRAVEL) && committed_motor &&
                          (travel_cnt == CNT_LAST);
    end

    // SCAN search: nearest pending floor strictly above and strictly below the car
    always_comb begin
        up_found = 1'b0;
        up_floor = '0;
        dn_found = 1'b0;
        dn_floor = '0;
        // Descending walk: the last hit above the car is the closest one
        for (int f = FLOORS - 1; f >= 0; f--) begin
            if (pending[f] && (FLOOR_W'(f) > current_floor)) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(f);
            end
        end
        // Ascending walk: the last hit below the car is the closest one
        for (int f = 0; f < FLOORS; f++) begin
            if (pending[f] && (FLOOR_W'(f) < current_floor)) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(f);
            end
        end
        // Keep the current direction while it has work, otherwise reverse
        sel_up    = dir_up ? up_found : !dn_found;
        sel_floor = sel_up ? up_floor : dn_floor;
    end

    // Next floor for a completed travel interval, saturating at the shaft ends
    always_comb begin
        step_oob   = 1'b0;
        step_floor = current_floor;
        if (dir_up) begin
            if (current_floor >= TOP_FLOOR) begin
                step_oob = 1'b1;
            end else begin
                step_floor = current_floor + FLOOR_W'(1);
            end
        end else begin
            if (current_floor == '0) begin
                step_oob = 1'b1;
            end else begin
                step_floor = current_floor - FLOOR_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= D_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            D_IDLE:   if (dispatch) state_nxt = D_REQ;
            D_REQ:    if (committed_motor) state_nxt = D_TRAVEL;
            D_TRAVEL: if (step_due && (step_floor == target_floor)) state_nxt = D_ARRIVE;
            D_ARRIVE: if (door_motor_open) state_nxt = D_DOOR;
            D_DOOR:   if (door_motor_close) state_nxt = D_IDLE;
            default:  state_nxt = D_IDLE;
        endcase
    end

    // Output and datapath next values per state
    always_comb begin
        button_up_nxt     = button_up;
        button_down_nxt   = button_down;
        door_open_nxt     = door_open;
        current_floor_nxt = current_floor;
        target_floor_nxt  = target_floor;
        travel_cnt_nxt    = travel_cnt;
        dir_up_nxt        = dir_up;
        fault_nxt         = fault;
        clear_mask        = '0;
        case (state)
            D_IDLE: begin
                if (motors_quiet && here_pending) begin
                    // Call at the floor we are already on: serve it without moving
                    clear_mask = floor_bit(current_floor);
                end else if (dispatch) begin
                    target_floor_nxt = sel_floor;
                    dir_up_nxt       = sel_up;
                    button_up_nxt    = sel_up;
                    button_down_nxt  = !sel_up;
                end
            end
            D_REQ: begin
                if (wrong_dir) begin
                    fault_nxt = 1'b1;
                end
                if (committed_motor) begin
                    button_up_nxt   = 1'b0;
                    button_down_nxt = 1'b0;
                    travel_cnt_nxt  = '0;
                end
            end
            D_TRAVEL: begin
                if (wrong_dir) begin
                    fault_nxt = 1'b1;
                end
                if (committed_motor) begin
                    if (travel_cnt == CNT_LAST) begin
                        current_floor_nxt = step_floor;
                        travel_cnt_nxt    = '0;
                        if (step_oob) begin
                            fault_nxt = 1'b1;
                        end
                        // Stop request goes out on the same edge as the last step
                        if (step_floor == target_floor) begin
                            door_open_nxt = 1'b1;
                        end
                    end else begin
                        travel_cnt_nxt = travel_cnt + CNT_W'(1);
                    end
                end
            end
            D_ARRIVE: begin
                if (door_motor_open) begin
                    door_open_nxt = 1'b0;
                end
            end
            D_DOOR: begin
                if (door_motor_close) begin
                    clear_mask = floor_bit(target_floor);
                end
            end
            default: begin
                clear_mask = '0;
            end
        endcase
    end

    // Registered outputs, position tracking and call latch; a new call wins over a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            button_up     <= 1'b0;
            button_down   <= 1'b0;
            door_open     <= 1'b0;
            current_floor <= '0;
            target_floor  <= '0;
            pending       <= '0;
            travel_cnt    <= '0;
            dir_up        <= 1'b1;
            fault         <= 1'b0;
        end else begin
            button_up     <= button_up_nxt;
            button_down   <= button_down_nxt;
            door_open     <= door_open_nxt;
            current_floor <= current_floor_nxt;
            target_floor  <= target_floor_nxt;
            pending       <= (pending & ~clear_mask) | call_req;
            travel_cnt    <= travel_cnt_nxt;
            dir_up        <= dir_up_nxt;
            fault         <= fault_nxt;
        end
    end

    assign busy = (state != D_IDLE);

endmodule
